half_subtractor: RTL and testbench

Bit-level subtraction primitive computing a − b per lane: difference and borrow-out. Two outputs are provided:
- a zero-latency combinational result, used when full subtractors are built from two half subtractors plus an OR of the borrows;
- a one-cycle registered copy with a valid flag and a saturating borrow-event counter, for pipelined datapaths and debug visibility.

---
 rtl/half_subtractor_pkg.sv | 13 +
 rtl/half_subtractor_if.sv | 31 +++
 rtl/half_subtractor_lane.sv | 13 +
 rtl/half_subtractor.sv | 80 ++++++++
 tb/tb_half_subtractor.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/half_subtractor_pkg.sv
// Shared constants and the single-bit subtraction rule for the half_subtractor
// family, reused by full-subtractor blocks built from two cells.
package half_subtractor_pkg;

  localparam int HS_WIDTH = 1;
  localparam int HS_CNT_W = 16;

  // Returns {borrow, diff} for one bit of a - b.
  function automatic logic [1:0] hs_lane(input logic a, input logic b);
    return {~a & b, a ^ b};
  endfunction

endpackage : half_subtractor_pkg

// File: rtl/half_subtractor_if.sv
// Operand/result bundle for half_subtractor: the master side drives operands
// and controls, the slave side (the subtractor) returns results.
interface half_subtractor_if
  import half_subtractor_pkg::*;
#(
  parameter int WIDTH = HS_WIDTH,
  parameter int CNT_W = HS_CNT_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             cnt_clr;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] borrow_q;
  logic             out_valid;
  logic [CNT_W-1:0] borrow_cnt;

  modport master (
    output a, b, in_valid, cnt_clr,
    input  diff, borrow, diff_q, borrow_q, out_valid, borrow_cnt
  );

  modport slave (
    input  a, b, in_valid, cnt_clr,
    output diff, borrow, diff_q, borrow_q, out_valid, borrow_cnt
  );

endinterface : half_subtractor_if

// File: rtl/half_subtractor_lane.sv
// Single-bit combinational half-subtractor cell: diff = a ^ b, borrow = ~a & b.
module half_subtractor_lane
  import half_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign {borrow, diff} = hs_lane(a, b);

endmodule : half_subtractor_lane

// File: rtl/half_subtractor.sv
// WIDTH independent half-subtractor lanes with a zero-latency result, a
// one-cycle registered copy and a saturating count of borrowing samples.
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int WIDTH = HS_WIDTH,
  parameter int CNT_W = HS_CNT_W
)
(
  input logic              clk,
  input logic              rst_n,
  half_subtractor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] borrow_w;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] borrow_q;
  logic             out_valid;
  logic [CNT_W-1:0] borrow_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             any_borrow;

  // Lanes never exchange borrows; each is a standalone cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_subtractor_lane u_lane (
      .a      (bus.a[i]),
      .b      (bus.b[i]),
      .diff   (diff_w[i]),
      .borrow (borrow_w[i])
    );
  end

  assign any_borrow = |borrow_w;

  // NOTE: the reset branch sits in the sensitivity list so outputs clear the
  // moment rst_n falls; <= keeps every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q    <= '0;
      borrow_q  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        diff_q   <= diff_w;
        borrow_q <= borrow_w;
      end
    end
  end

  // NOTE: cnt_next gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cnt_next = borrow_cnt;
    if (bus.cnt_clr) begin
      cnt_next = '0;
    end else if (bus.in_valid && any_borrow && (borrow_cnt != CNT_MAX)) begin
      cnt_next = borrow_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_cnt <= '0;
    end else begin
      borrow_cnt <= cnt_next;
    end
  end

  assign bus.diff       = diff_w;
  assign bus.borrow     = borrow_w;
  assign bus.diff_q     = diff_q;
  assign bus.borrow_q   = borrow_q;
  assign bus.out_valid  = out_valid;
  assign bus.borrow_cnt = borrow_cnt;

endmodule : half_subtractor

// File: tb/tb_half_subtractor.sv
// Bench for half_subtractor: directed scenarios plus randomized traffic on a
// 4-lane/2-bit-counter instance and a 1-lane/16-bit-counter instance.
module tb_half_subtractor;

  int checks   = 0;
  int failures = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  half_subtractor_if #(.WIDTH(4), .CNT_W(2))  if4 ();
  half_subtractor_if #(.WIDTH(1), .CNT_W(16)) if1 ();

  half_subtractor #(.WIDTH(4), .CNT_W(2)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  half_subtractor #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  // Full subtractor composed from two cells plus an OR of the borrows.
  logic fx, fy, fbin, fd1, fb1, fdiff, fb2, fbout;
  half_subtractor_lane u_fs_hi (.a(fx),  .b(fy),   .diff(fd1),   .borrow(fb1));
  half_subtractor_lane u_fs_lo (.a(fd1), .b(fbin), .diff(fdiff), .borrow(fb2));
  assign fbout = fb1 | fb2;

  // Reference model state: values the registered outputs must show after the
  // next edge.
  logic [3:0] m4_dq, m4_bq;
  logic       m4_v;
  int         m4_cnt;
  logic       m1_dq, m1_bq;
  logic       m1_v;
  int         m1_cnt;

  // Per-lane integer subtraction: difference bit is (a-b) != 0, borrow is (a-b) < 0.
  // Returns {borrow[7:0], diff[7:0]}.
  function automatic logic [15:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input int w);
    logic [7:0] d, bo;
    d  = '0;
    bo = '0;
    for (int i = 0; i < w; i++) begin
      int r;
      r     = int'(a[i]) - int'(b[i]);
      d[i]  = (r != 0);
      bo[i] = (r < 0);
    end
    return {bo, d};
  endfunction

  task automatic model_reset();
    m4_dq = '0; m4_bq = '0; m4_v = 1'b0; m4_cnt = 0;
    m1_dq = 1'b0; m1_bq = 1'b0; m1_v = 1'b0; m1_cnt = 0;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic iv, input logic clr);
    logic [15:0] r;
    r = ref_sub({4'b0, a}, {4'b0, b}, 4);
    if4.a = a; if4.b = b; if4.in_valid = iv; if4.cnt_clr = clr;
    if (clr) m4_cnt = 0;
    else if (iv && (r[11:8] != 8'h0)) m4_cnt = (m4_cnt + 1 > 3) ? 3 : m4_cnt + 1;
    if (iv) begin m4_dq = r[3:0]; m4_bq = r[11:8]; end
    m4_v = iv;
  endtask

  task automatic drive1(input logic a, input logic b, input logic iv, input logic clr);
    logic [15:0] r;
    r = ref_sub({7'b0, a}, {7'b0, b}, 1);
    if1.a = a; if1.b = b; if1.in_valid = iv; if1.cnt_clr = clr;
    if (clr) m1_cnt = 0;
    else if (iv && r[8]) m1_cnt = (m1_cnt + 1 > 65535) ? 65535 : m1_cnt + 1;
    if (iv) begin m1_dq = r[0]; m1_bq = r[8]; end
    m1_v = iv;
  endtask

  task automatic test_reset();
    drive4(4'h0, 4'h0, 1'b0, 1'b0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (if4.diff_q !== 4'h0)    begin failures++; $display("FAIL rst_diff_q got=%h exp=0", if4.diff_q); end
    checks++; if (if4.borrow_q !== 4'h0)  begin failures++; $display("FAIL rst_borrow_q got=%h exp=0", if4.borrow_q); end
    checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", if4.out_valid); end
    checks++; if (if4.borrow_cnt !== 2'd0) begin failures++; $display("FAIL rst_borrow_cnt got=%0d exp=0", if4.borrow_cnt); end
    checks++; if (if1.borrow_cnt !== 16'd0) begin failures++; $display("FAIL rst_borrow_cnt1 got=%0d exp=0", if1.borrow_cnt); end
    // Combinational path keeps working while reset is held.
    if4.a = 4'b0101; if4.b = 4'b0011;
    #1;
    checks++; if (if4.diff !== 4'b0110)   begin failures++; $display("FAIL rst_comb_diff got=%b exp=0110", if4.diff); end
    checks++; if (if4.borrow !== 4'b0010) begin failures++; $display("FAIL rst_comb_borrow got=%b exp=0010", if4.borrow); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_comb_exhaustive();
    logic exp_d [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_b [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      if1.a = v[1]; if1.b = v[0];
      #1;
      checks++;
      if ({if1.diff, if1.borrow} !== {exp_d[i], exp_b[i]}) begin
        failures++;
        $display("FAIL comb_ab%b got=%b%b exp=%b%b", v, if1.diff, if1.borrow, exp_d[i], exp_b[i]);
      end
    end
    if1.a = 1'b0; if1.b = 1'b0;
  endtask

  task automatic test_latency();
    @(negedge clk) drive4(4'b0101, 4'b0011, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (if4.diff_q !== 4'b0110)   begin failures++; $display("FAIL lat_diff_q got=%b exp=0110", if4.diff_q); end
    checks++; if (if4.borrow_q !== 4'b0010) begin failures++; $display("FAIL lat_borrow_q got=%b exp=0010", if4.borrow_q); end
    checks++; if (if4.out_valid !== 1'b1)   begin failures++; $display("FAIL lat_out_valid got=%b exp=1", if4.out_valid); end
    @(negedge clk) drive4(4'b1111, 4'b0000, 1'b0, 1'b0);
    #1;
    checks++; if (if4.diff !== 4'b1111)     begin failures++; $display("FAIL lat_comb_diff got=%b exp=1111", if4.diff); end
    checks++; if (if4.borrow !== 4'b0000)   begin failures++; $display("FAIL lat_comb_borrow got=%b exp=0000", if4.borrow); end
    @(posedge clk); #1;
    checks++; if (if4.out_valid !== 1'b0)   begin failures++; $display("FAIL lat_valid_drop got=%b exp=0", if4.out_valid); end
    checks++; if (if4.diff_q !== 4'b0110)   begin failures++; $display("FAIL lat_diff_hold got=%b exp=0110", if4.diff_q); end
    checks++; if (if4.borrow_q !== 4'b0010) begin failures++; $display("FAIL lat_borrow_hold got=%b exp=0010", if4.borrow_q); end
  endtask

  task automatic test_async_reset();
    @(negedge clk) drive4(4'b0000, 4'b1010, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (if4.diff_q !== 4'b1010) begin failures++; $display("FAIL ar_pre_diff_q got=%b exp=1010", if4.diff_q); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (if4.diff_q !== 4'h0)     begin failures++; $display("FAIL ar_diff_q got=%b exp=0000", if4.diff_q); end
    checks++; if (if4.borrow_q !== 4'h0)   begin failures++; $display("FAIL ar_borrow_q got=%b exp=0000", if4.borrow_q); end
    checks++; if (if4.out_valid !== 1'b0)  begin failures++; $display("FAIL ar_out_valid got=%b exp=0", if4.out_valid); end
    checks++; if (if4.borrow_cnt !== 2'd0) begin failures++; $display("FAIL ar_borrow_cnt got=%0d exp=0", if4.borrow_cnt); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive4(4'b1111, 4'b0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if (if4.out_valid !== 1'b0)  begin failures++; $display("FAIL ar_post_valid got=%b exp=0", if4.out_valid); end
    checks++; if (if4.diff_q !== 4'h0)     begin failures++; $display("FAIL ar_post_diff_q got=%b exp=0000", if4.diff_q); end
  endtask

  task automatic test_counter_sat();
    int exp_seq [5] = '{1, 2, 3, 3, 3};
    @(negedge clk) drive4(4'h0, 4'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++; if (if4.borrow_cnt !== 2'd0) begin failures++; $display("FAIL cnt_clear got=%0d exp=0", if4.borrow_cnt); end
    @(negedge clk) drive4(4'b1111, 4'b1111, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (if4.borrow_cnt !== 2'd0) begin failures++; $display("FAIL cnt_no_borrow got=%0d exp=0", if4.borrow_cnt); end
    @(negedge clk) drive4(4'b0000, 4'b0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if (if4.borrow_cnt !== 2'd0) begin failures++; $display("FAIL cnt_not_valid got=%0d exp=0", if4.borrow_cnt); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) drive4(4'b0000, 4'b0001, 1'b1, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (if4.borrow_cnt !== 2'(exp_seq[i])) begin
        failures++;
        $display("FAIL cnt_seq%0d got=%0d exp=%0d", i, if4.borrow_cnt, exp_seq[i]);
      end
    end
  endtask

  task automatic test_clr_priority();
    @(negedge clk) drive4(4'b0000, 4'b0001, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (if4.borrow_cnt !== 2'd0) begin failures++; $display("FAIL clr_at_max got=%0d exp=0", if4.borrow_cnt); end
    @(negedge clk) drive4(4'b0000, 4'b0001, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (if4.borrow_cnt !== 2'd1) begin failures++; $display("FAIL clr_restart got=%0d exp=1", if4.borrow_cnt); end
    @(negedge clk) drive4(4'b0000, 4'b0001, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (if4.borrow_cnt !== 2'd0) begin failures++; $display("FAIL clr_wins got=%0d exp=0", if4.borrow_cnt); end
  endtask

  task automatic test_full_sub();
    logic exp_d [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_b [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {fx, fy, fbin} = v;
      #1;
      checks++;
      if ({fdiff, fbout} !== {exp_d[i], exp_b[i]}) begin
        failures++;
        $display("FAIL fs_xyb%b got=%b%b exp=%b%b", v, fdiff, fbout, exp_d[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [15:0] r4, r1;
      @(negedge clk);
      if (n % 97 == 96) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({if4.out_valid, if4.borrow_cnt, if1.out_valid, if1.borrow_cnt} !== 20'h0) begin
          failures++;
          $display("FAIL rnd_reset n=%0d got v4=%b c4=%0d v1=%b c1=%0d exp=0", n,
                   if4.out_valid, if4.borrow_cnt, if1.out_valid, if1.borrow_cnt);
        end
        #1 rst_n = 1'b1;
      end
      drive4(4'($urandom), 4'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      drive1(1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
      r4 = ref_sub({4'b0, if4.a}, {4'b0, if4.b}, 4);
      r1 = ref_sub({7'b0, if1.a}, {7'b0, if1.b}, 1);
      #1;
      checks++;
      if ({if4.diff, if4.borrow} !== {r4[3:0], r4[11:8]}) begin
        failures++;
        $display("FAIL rnd_comb4 n=%0d got=%b/%b exp=%b/%b", n, if4.diff, if4.borrow, r4[3:0], r4[11:8]);
      end
      checks++;
      if ({if1.diff, if1.borrow} !== {r1[0], r1[8]}) begin
        failures++;
        $display("FAIL rnd_comb1 n=%0d got=%b/%b exp=%b/%b", n, if1.diff, if1.borrow, r1[0], r1[8]);
      end
      @(posedge clk); #1;
      checks++;
      if ({if4.diff_q, if4.borrow_q, if4.out_valid, if4.borrow_cnt} !== {m4_dq, m4_bq, m4_v, 2'(m4_cnt)}) begin
        failures++;
        $display("FAIL rnd_reg4 n=%0d got dq=%b bq=%b v=%b c=%0d exp dq=%b bq=%b v=%b c=%0d", n,
                 if4.diff_q, if4.borrow_q, if4.out_valid, if4.borrow_cnt, m4_dq, m4_bq, m4_v, m4_cnt);
      end
      checks++;
      if ({if1.diff_q, if1.borrow_q, if1.out_valid, if1.borrow_cnt} !== {m1_dq, m1_bq, m1_v, 16'(m1_cnt)}) begin
        failures++;
        $display("FAIL rnd_reg1 n=%0d got dq=%b bq=%b v=%b c=%0d exp dq=%b bq=%b v=%b c=%0d", n,
                 if1.diff_q, if1.borrow_q, if1.out_valid, if1.borrow_cnt, m1_dq, m1_bq, m1_v, m1_cnt);
      end
    end
  endtask

  initial begin
    {fx, fy, fbin} = 3'b000;
    test_reset();
    test_comb_exhaustive();
    test_latency();
    test_async_reset();
    test_counter_sat();
    test_clr_priority();
    test_full_sub();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_half_subtractor
